conv_seq_ctrl: RTL

CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

---
 rtl/conv_seq_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/conv_seq_ctrl.sv
// rtl/conv_seq_ctrl.sv - sequencer that drives a shared MAC over eight output positions
//
// Purpose: on start, requests one MAC result per position 0..7, collects the
// bytes into res_flat and then pulses disp_start to the display controller.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   start       in   run request, sampled only while idle
//   mac_ack     in   MAC result valid for the current request
//   mac_result  in   8-bit MAC result
//   mac_req     out  one-cycle request for position mac_idx
//   mac_idx     out  position being computed (0..7)
//   res_flat    out  results, position k at bits [8k+7:8k]
//   disp_start  out  one-cycle pulse to the display controller
//   busy        out  high whenever the sequencer is not idle
//   err         out  sticky wait-timeout flag
//
// Build option: define CONV_SEQ_TIMEOUT_EN to add an 8-bit wait timeout that
// substitutes 8'hFF for a missing result and raises err. Without it a missing
// ack stalls the sequencer in WAIT and err is tied low.

module conv_seq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mac_ack,
    input  logic [7:0]  mac_result,
    output logic        mac_req,
    output logic [2:0]  mac_idx,
    output logic [63:0] res_flat,
    output logic        disp_start,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    state_t     state;
    logic [2:0] idx;
    logic       cap_en;
    logic [7:0] cap_byte;

    assign mac_idx = idx;

`ifdef CONV_SEQ_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       timeout;

    // wait_cnt is 0 in the first WAIT cycle, so when it reads 254 this is the
    // 255th WAIT cycle without an ack and the count would reach 255 here.
    assign timeout = (state == WAIT) && !mac_ack && (wait_cnt == 8'd254);
`endif

    // A position completes on an ack, or on a timeout when that is compiled in.
    always_comb begin
        cap_en   = (state == WAIT) && mac_ack;
        cap_byte = mac_result;
`ifdef CONV_SEQ_TIMEOUT_EN
        if (timeout) begin
            cap_en   = 1'b1;
            cap_byte = 8'hFF;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= 3'd0;
            res_flat   <= 64'd0;
            mac_req    <= 1'b0;
            disp_start <= 1'b0;
            busy       <= 1'b0;
`ifdef CONV_SEQ_TIMEOUT_EN
            err        <= 1'b0;
            wait_cnt   <= 8'd0;
`endif
        end else begin
            // Pulse outputs default low; they are raised on the edge that
            // enters the state they belong to, so they line up with it.
            mac_req    <= 1'b0;
            disp_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= REQ;
                        idx      <= 3'd0;
                        res_flat <= 64'd0;
                        mac_req  <= 1'b1;
                        busy     <= 1'b1;
`ifdef CONV_SEQ_TIMEOUT_EN
                        err      <= 1'b0;
`endif
                    end
                end
                REQ: begin
                    state <= WAIT;
`ifdef CONV_SEQ_TIMEOUT_EN
                    wait_cnt <= 8'd0;
`endif
                end
                WAIT: begin
                    if (cap_en) begin
                        res_flat[{idx, 3'b000} +: 8] <= cap_byte;
`ifdef CONV_SEQ_TIMEOUT_EN
                        if (timeout) begin
                            err <= 1'b1;
                        end
`endif
                        if (idx == 3'd7) begin
                            state      <= DONE;
                            disp_start <= 1'b1;
                        end else begin
                            idx     <= idx + 3'd1;
                            state   <= REQ;
                            mac_req <= 1'b1;
                        end
                    end
`ifdef CONV_SEQ_TIMEOUT_EN
                    else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifndef CONV_SEQ_TIMEOUT_EN
    assign err = 1'b0;
`endif

endmodule
